fft_unloader: RTL and testbench
===============================

FFT_UNLOADER -- requirements
Module: fft_unloader

Interface
- REQ-001 ADDR_W, default 5: result-memory address width; transform length N = 2^ADDR_W.
- REQ-002 DATA_W, default 32: result word width (packed re/im, opaque to this block).
- REQ-003 clk  input  1  single clock; all state changes on rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 start  input  1  single-cycle request to unload a completed transform; sampled only in IDLE.
- REQ-006 busy  output  1  high from the cycle after accepted start until the done cycle, inclusive.
- REQ-007 rd_en  output  1  result-memory read strobe.
- REQ-008 rd_addr  output  ADDR_W  result-memory read address; meaningful only while rd_en=1.
- REQ-009 rd_data  input  DATA_W  memory read data; valid exactly 1 cycle after the matching rd_en.
- REQ-010 out_data  output  DATA_W  streamed result word.
- REQ-011 out_index  output  ADDR_W  natural-order bin number of out_data.
- REQ-012 out_valid  output  1  out_data/out_index/out_last valid.
- REQ-013 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
- REQ-014 out_last  output  1  high with the word whose out_index = N-1.
- REQ-015 done  output  1  one-cycle pulse after the final transfer.

Function
- REQ-016 FSM states IDLE, READ, DRAIN, FIN; IDLE->READ on start; READ->DRAIN after the read for k=N-1 is issued; DRAIN->FIN on transfer of the out_last word; FIN->IDLE unconditionally after 1 cycle.
- REQ-017 Read counter k counts 0..N-1; rd_addr = bit-reverse of k over ADDR_W bits (ADDR_W=5: k=1 -> 16, k=3 -> 24, k=31 -> 31).
- REQ-018 Output buffer: 2-entry FIFO of {rd_data, k}; entry written in the cycle rd_data is valid, never dropped.
- REQ-019 rd_en = 1 only in READ and only when (FIFO occupancy + reads in flight) < 2, counted before this cycle's pop; k increments on each rd_en.
- REQ-020 Simultaneous pop and push in the same cycle SHALL leave occupancy unchanged and preserve order.
- REQ-021 out_valid = FIFO non-empty; out_data/out_index/out_last driven from FIFO head, stable while out_valid && !out_ready.
- REQ-022 With out_ready held high, throughput is 1 word/cycle: first rd_en in the cycle after start, first out_valid 2 cycles after start, N transfers in N consecutive cycles.
- REQ-023 out_index sequence SHALL be exactly 0,1,...,N-1, no gaps or repeats, regardless of out_ready pattern.
- REQ-024 done asserts in FIN (the cycle after the out_last transfer); busy deasserts the cycle after done.
- REQ-025 start while not IDLE SHALL be ignored; start in FIN ignored; start in IDLE with done-cycle overlap impossible by construction.
- REQ-026 out_valid deasserted and rd_en = 0 in IDLE and FIN.

Reset
- REQ-027 reset=1 at a clock edge: state IDLE, k=0, FIFO emptied, in-flight read discarded, all outputs 0 (busy, rd_en, rd_addr, out_valid, out_data, out_index, out_last, done).
- REQ-028 reset mid-unload aborts without done; next start restarts from k=0.
- REQ-029 reset overrides start in the same cycle.

Verification
- REQ-030 ADDR_W=5, memory[a]=a, start pulse, out_ready=1 -> rd_addr 0,16,8,24,4,...,31 on consecutive cycles; out_data=bitrev(out_index); 32 transfers; done at cycle 34 after start.
- REQ-031 out_ready toggled 1/0 each cycle -> same 32-word ordered sequence, no duplicates; rd_en never leaves >2 words outstanding; out_* stable during stalls.
- REQ-032 out_ready=0 for 10 cycles after start -> exactly 2 rd_en pulses (addr 0,16), then no reads until ready; data held at index 0.
- REQ-033 start pulsed again at cycle 10 of an unload -> ignored; exactly one done, 32 transfers.
- REQ-034 reset asserted after 12 transfers -> next cycle all outputs 0, FIFO empty, no done; new start yields out_index from 0 and rd_addr=0 first.
- REQ-035 Random out_ready (50%) over 20 back-to-back unloads -> scoreboard matches bitrev order each run; busy/done timing per REQ-024.

Source files
------------

// File: rtl/fft_unloader.sv
// Streams a completed FFT result memory out in natural bin order by reading
// bit-reversed addresses through a 2-deep skid FIFO with ready/valid backpressure.
module fft_unloader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] k, k_n;
    logic              infl, infl_n;
    logic [ADDR_W-1:0] infl_idx, infl_idx_n;
    logic              s0_v, s0_v_n, s1_v, s1_v_n;
    logic [DATA_W-1:0] s0_d, s0_d_n, s1_d, s1_d_n;
    logic [ADDR_W-1:0] s0_i, s0_i_n, s1_i, s1_i_n;
    logic              busy_n, rd_en_n, done_n;
    logic [ADDR_W-1:0] rd_addr_n;

    logic              head_v, pop, push_arr;
    logic [DATA_W-1:0] head_d;
    logic [ADDR_W-1:0] head_i;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = v[int'(ADDR_W) - 1 - i];
        end
        return r;
    endfunction

    // Head of the logical FIFO: oldest stored entry, else the word arriving from memory.
    always_comb begin
        head_v    = s0_v | infl;
        head_d    = s0_v ? s0_d : rd_data;
        head_i    = s0_v ? s0_i : infl_idx;
        out_valid = head_v;
        out_data  = head_v ? head_d : '0;
        out_index = head_v ? head_i : '0;
        out_last  = head_v && (head_i == LAST_IDX);
        pop       = head_v && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            k        <= '0;
            infl     <= 1'b0;
            infl_idx <= '0;
            s0_v     <= 1'b0;
            s0_d     <= '0;
            s0_i     <= '0;
            s1_v     <= 1'b0;
            s1_d     <= '0;
            s1_i     <= '0;
            busy     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            infl     <= infl_n;
            infl_idx <= infl_idx_n;
            s0_v     <= s0_v_n;
            s0_d     <= s0_d_n;
            s0_i     <= s0_i_n;
            s1_v     <= s1_v_n;
            s1_d     <= s1_d_n;
            s1_i     <= s1_i_n;
            busy     <= busy_n;
            rd_en    <= rd_en_n;
            rd_addr  <= rd_addr_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        k_n        = k;
        infl_n     = rd_en;
        infl_idx_n = k;
        s0_v_n     = s0_v;
        s0_d_n     = s0_d;
        s0_i_n     = s0_i;
        s1_v_n     = s1_v;
        s1_d_n     = s1_d;
        s1_i_n     = s1_i;
        push_arr   = 1'b0;

        unique case (state)
            S_IDLE:  if (start) state_n = S_READ;
            S_READ:  if (rd_en && (k == LAST_IDX)) state_n = S_DRAIN;
            S_DRAIN: if (pop && (head_i == LAST_IDX)) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        k_n = (state == S_IDLE) ? '0 : k + ADDR_W'(rd_en);

        // Pop shifts the tail forward; an arriving word that was popped directly is not stored.
        if (pop) begin
            s0_v_n = s1_v;
            s0_d_n = s1_d;
            s0_i_n = s1_i;
            s1_v_n = 1'b0;
        end
        push_arr = infl && !(pop && !s0_v);
        if (push_arr) begin
            if (!s0_v_n) begin
                s0_v_n = 1'b1;
                s0_d_n = rd_data;
                s0_i_n = infl_idx;
            end else begin
                s1_v_n = 1'b1;
                s1_d_n = rd_data;
                s1_i_n = infl_idx;
            end
        end

        // Issue next cycle only if stored words plus the read landing then leave room.
        rd_en_n   = (state_n == S_READ) &&
                    ((2'(s0_v_n) + 2'(s1_v_n) + 2'(rd_en)) < 2'd2);
        rd_addr_n = rd_en_n ? bitrev(k_n) : '0;
        busy_n    = (state_n != S_IDLE);
        done_n    = (state_n == S_FIN);
    end

endmodule

// File: tb/tb_fft_unloader.sv
// Self-checking bench for fft_unloader: randomized memory contents and out_ready
// patterns checked against a natural-order / bit-reversal reference model.
module tb_fft_unloader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic          busy, rd_en, out_valid, out_last, done;
    logic [AW-1:0] rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data;

    logic [DW-1:0] mem [N];

    int tests = 0;
    int fails = 0;

    // Observations collected by unload()
    int            xi[$];
    logic [DW-1:0] xd[$];
    int            ra[$];
    int            rc[$];
    int            dc[$];
    int            first_xfer, last_xfer;
    int            busy_err, stall_err, out_err, last_err;
    bit            timed_out, snap_v, zero_ok;
    int            snap_idx, reads_by10;

    fft_unloader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Result memory with one-cycle read latency; junk when not reading.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr] : $urandom;
    end

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) r |= ((v >> i) & 1) << (AW - 1 - i);
        return r;
    endfunction

    function automatic void fill_mem(input bit identity);
        for (int a = 0; a < N; a++) mem[a] = identity ? DW'(a) : $urandom;
    endfunction

    // First position where transfers deviate from the natural-order model; -1 if exact.
    function automatic int seq_bad();
        if (xi.size() != N) return -2;
        for (int i = 0; i < N; i++)
            if (xi[i] != i || xd[i] !== mem[bitrev(i)]) return i;
        return -1;
    endfunction

    function automatic int addr_bad();
        if (ra.size() != N) return -2;
        for (int i = 0; i < N; i++) if (ra[i] != bitrev(i)) return i;
        return -1;
    endfunction

    function automatic bit pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return 1'($urandom % 2);
            default: return cyc > 10;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one unload (start at cycle 0) and records what the DUT does.
    task automatic unload(input int mode, input int abort_at, input bit restart10);
        int cyc, issued, done_at, pi;
        bit pv, pr, pl, rdy;
        logic [DW-1:0] pd;
        xi.delete(); xd.delete(); ra.delete(); rc.delete(); dc.delete();
        first_xfer = -1; last_xfer = -1; busy_err = 0; stall_err = 0;
        out_err = 0; last_err = 0; timed_out = 0; snap_v = 0; snap_idx = -1;
        reads_by10 = -1; zero_ok = 0; issued = 0; done_at = -1;
        pv = 0; pr = 0; pl = 0; pi = 0; pd = '0;
        @(negedge clk);
        cyc = 0; start = 1'b1; out_ready = pick_ready(mode, 0);
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            cyc++;
            start = restart10 && (cyc == 10);
            if (done_at < 0) begin
                if (busy !== 1'b1) busy_err++;
            end else if (busy !== 1'b0 || done !== 1'b0) busy_err++;
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd ||
                              int'(out_index) != pi || out_last !== pl)) stall_err++;
            if (rd_en === 1'b1) begin
                ra.push_back(int'(rd_addr)); rc.push_back(cyc); issued++;
            end
            if (issued - xi.size() > 2) out_err++;
            if (cyc == 10) begin
                snap_v = out_valid; snap_idx = int'(out_index); reads_by10 = ra.size();
            end
            if (done === 1'b1) begin
                dc.push_back(cyc);
                if (done_at < 0) done_at = cyc;
            end
            rdy = pick_ready(mode, cyc);
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                xi.push_back(int'(out_index)); xd.push_back(out_data);
                if (out_last !== (int'(out_index) == N - 1)) last_err++;
            end
            pv = (out_valid === 1'b1); pr = rdy; pd = out_data;
            pi = int'(out_index); pl = out_last;
            if (abort_at >= 0 && xi.size() == abort_at) begin
                reset = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                zero_ok = {busy, rd_en, rd_addr, out_valid, out_data, out_index,
                           out_last, done} === '0;
                reset = 1'b0;
                @(negedge clk);
                if (done === 1'b1 || out_valid === 1'b1) zero_ok = 0;
                return;
            end
            if (done_at >= 0 && cyc == done_at + 1) return;
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({busy, rd_en, rd_addr, out_valid, out_index, out_last, done} !== '0) begin
            fails++; $display("FAIL reset_ctrl got=%b want=0",
                {busy, rd_en, rd_addr, out_valid, out_index, out_last, done});
        end
        tests++;
        if (out_data !== '0) begin
            fails++; $display("FAIL reset_data got=%h want=0", out_data);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_over_start busy=%b want=0", busy);
        end
    endtask

    task automatic test_stream();
        int bad = -1;
        fill_mem(1);
        unload(0, -1, 0);
        tests++;
        if (timed_out || addr_bad() != -1) begin
            fails++; $display("FAIL stream_addr timeout=%0d bad_at=%0d want=-1", timed_out, addr_bad());
        end
        for (int i = 0; i < rc.size(); i++) if (rc[i] != i + 1 && bad < 0) bad = i;
        tests++;
        if (bad != -1 || rc.size() != N) begin
            fails++; $display("FAIL stream_rd_cycles bad_at=%0d n=%0d want=%0d consecutive from 1", bad, rc.size(), N);
        end
        tests++;
        if (seq_bad() != -1) begin
            fails++; $display("FAIL stream_seq bad_at=%0d want=-1", seq_bad());
        end
        tests++;
        if (first_xfer != 2 || last_xfer != N + 1) begin
            fails++; $display("FAIL stream_xfer_window got=%0d..%0d want=2..%0d", first_xfer, last_xfer, N + 1);
        end
        tests++;
        if (dc.size() != 1 || dc[0] != N + 2) begin
            fails++; $display("FAIL stream_done n=%0d at=%0d want at %0d", dc.size(),
                dc.size() > 0 ? dc[0] : -1, N + 2);
        end
        tests++;
        if (busy_err != 0 || last_err != 0) begin
            fails++; $display("FAIL stream_busy_last busy_err=%0d last_err=%0d want 0", busy_err, last_err);
        end
    endtask

    task automatic test_toggle();
        fill_mem(0);
        unload(1, -1, 0);
        tests++;
        if (timed_out || seq_bad() != -1) begin
            fails++; $display("FAIL toggle_seq timeout=%0d bad_at=%0d want=-1", timed_out, seq_bad());
        end
        tests++;
        if (out_err != 0 || stall_err != 0) begin
            fails++; $display("FAIL toggle_flow outstanding_err=%0d stall_err=%0d want 0", out_err, stall_err);
        end
        tests++;
        if (dc.size() != 1 || dc[0] != last_xfer + 1 || busy_err != 0) begin
            fails++; $display("FAIL toggle_done n=%0d busy_err=%0d want one done after last", dc.size(), busy_err);
        end
    endtask

    task automatic test_stall10();
        fill_mem(0);
        unload(3, -1, 0);
        tests++;
        if (reads_by10 != 2 || ra.size() < 2 || ra[0] != 0 || ra[1] != bitrev(1)) begin
            fails++; $display("FAIL stall_reads n=%0d want=2 addrs 0,%0d", reads_by10, bitrev(1));
        end
        tests++;
        if (snap_v !== 1'b1 || snap_idx != 0) begin
            fails++; $display("FAIL stall_hold valid=%0d idx=%0d want 1,0", snap_v, snap_idx);
        end
        tests++;
        if (timed_out || seq_bad() != -1 || stall_err != 0) begin
            fails++; $display("FAIL stall_seq bad_at=%0d stall_err=%0d want -1,0", seq_bad(), stall_err);
        end
    endtask

    task automatic test_restart_ignored();
        fill_mem(0);
        unload(0, -1, 1);
        tests++;
        if (timed_out || seq_bad() != -1 || dc.size() != 1 || dc[0] != N + 2) begin
            fails++; $display("FAIL restart_ignored bad_at=%0d dones=%0d want -1,1", seq_bad(), dc.size());
        end
    endtask

    task automatic test_abort();
        fill_mem(0);
        unload(2, 12, 0);
        tests++;
        if (!zero_ok || dc.size() != 0 || xi.size() != 12) begin
            fails++; $display("FAIL abort_zero zero_ok=%0d dones=%0d xfers=%0d want 1,0,12", zero_ok, dc.size(), xi.size());
        end
        unload(0, -1, 0);
        tests++;
        if (timed_out || ra.size() == 0 || ra[0] != 0 || seq_bad() != -1) begin
            fails++; $display("FAIL abort_restart first_addr=%0d bad_at=%0d want 0,-1",
                ra.size() > 0 ? ra[0] : -1, seq_bad());
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 20; r++) begin
            fill_mem(0);
            unload(2, -1, 0);
            tests++;
            if (timed_out || seq_bad() != -1) begin
                fails++; $display("FAIL b2b_seq run=%0d bad_at=%0d want=-1", r, seq_bad());
            end
            tests++;
            if (dc.size() != 1 || dc[0] != last_xfer + 1 || busy_err != 0 ||
                stall_err != 0 || out_err != 0 || last_err != 0) begin
                fails++; $display("FAIL b2b_ctrl run=%0d dones=%0d busy_err=%0d stall_err=%0d out_err=%0d last_err=%0d want 1,0,0,0,0",
                    r, dc.size(), busy_err, stall_err, out_err, last_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        fill_mem(1);
        test_reset();
        test_stream();
        test_toggle();
        test_stall10();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
